// File: rtl/and2_vec.sv
// ---------------------------------------------------------------------------
// and2_vec
//
// Purpose:
//   Registered bitwise AND of two equal-width vectors. The result c is
//   a & b delayed by one clock, driven straight from flops so there is no
//   combinational path from any input to the output. Serves as a minimal
//   synchronous datapath leaf and as a flow sanity-check design.
//
// Parameters:
//   WIDTH  bit width of a, b and c (>= 1), default 2.
//
// Ports:
//   clk    in   1      sole clock, all state updates on its rising edge
//   reset  in   1      synchronous active-high reset, clears the registers
//   a      in   WIDTH  operand A, sampled on rising clk
//   b      in   WIDTH  operand B, sampled on rising clk
//   c      out  WIDTH  registered result
//
// Optional build macro:
//   AND2_VEC_INPUT_REG_EN  when defined, a and b are first captured in
//                          input registers a_q / b_q (also cleared by
//                          reset) and c <= a_q & b_q, giving a total
//                          latency of 2 cycles. Port list and reset value
//                          are the same in both builds.
// ---------------------------------------------------------------------------
module and2_vec #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  // Operand values that feed the output AND. In the default build these are
  // the raw ports; with input registers they are the captured copies.
  logic [WIDTH-1:0] a_src;
  logic [WIDTH-1:0] b_src;

`ifdef AND2_VEC_INPUT_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Input capture stage. Cleared by reset so that c stays 0 for the first
  // edge after reset release, before real operands reach the AND.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign a_src = a_q;
  assign b_src = b_q;
`else
  assign a_src = a;
  assign b_src = b;
`endif

  // Output register. Reset overrides whatever operands are present; each
  // bit of c depends only on the same bit of the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
    end else begin
      c <= a_src & b_src;
    end
  end

endmodule

// File: tb/tb_and2_vec.sv
// ---------------------------------------------------------------------------
// tb_and2_vec
//
// Purpose:
//   Self-checking bench for and2_vec. A reference model records what was
//   presented at each rising edge and pushes the expected output into a
//   queue; an independent monitor pops and compares on each falling edge.
//   Latency follows the AND2_VEC_INPUT_REG_EN build macro.
// ---------------------------------------------------------------------------
module tb_and2_vec;

  localparam int WIDTH = 2;
`ifdef AND2_VEC_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  int errors;
  int checks;

  bit               modelOn;
  bit               seenReset;
  bit               histReset[$];
  logic [WIDTH-1:0] histA[$];
  logic [WIDTH-1:0] histB[$];
  logic [WIDTH-1:0] expQ[$];

  and2_vec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit i of the result is 1 exactly when bit i of both operands is 1.
  function automatic logic [WIDTH-1:0] refAnd(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((x[i] + y[i]) == 2) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Reference model: keep the last LAT edges of inputs. The output after
  // this edge is 0 if reset was seen in any of them, otherwise the AND of
  // the operands from LAT-1 edges ago. Nothing is predicted before the
  // first reset edge since c is undefined until then.
  always @(posedge clk) begin
    if (modelOn) begin
      bit               anyReset;
      logic [WIDTH-1:0] e;
      histReset.push_front(reset);
      histA.push_front(a);
      histB.push_front(b);
      if (histReset.size() > LAT) begin
        void'(histReset.pop_back());
        void'(histA.pop_back());
        void'(histB.pop_back());
      end
      if (reset) seenReset = 1'b1;
      if (seenReset) begin
        anyReset = 1'b0;
        foreach (histReset[i]) if (histReset[i]) anyReset = 1'b1;
        if (anyReset) e = '0;
        else          e = refAnd(histA[LAT-1], histB[LAT-1]);
        expQ.push_back(e);
      end
    end
  end

  task automatic checkOutput(input string name,
                             input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got c=%b expected c=%b at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  // Monitor: the output is stable away from the rising edge, so compare on
  // the falling edge whenever a prediction is waiting.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [WIDTH-1:0] e;
      e = expQ.pop_front();
      checkOutput("c_vs_model", c, e);
    end
  end

  // Inputs change on the falling edge, well clear of the sampling edge.
  task automatic applyStimulus(input bit r,
                               input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb);
    @(negedge clk);
    reset = r;
    a     = va;
    b     = vb;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    modelOn   = 1'b1;
    seenReset = 1'b0;
    reset     = 1'b1;
    a         = 2'b11;
    b         = 2'b11;

    // Reset hold with all-ones operands.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b11, 2'b11);

    // Release, then AND.
    applyStimulus(1'b0, 2'b11, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11);

    // Alternating toggles from 00, two rounds.
    applyStimulus(1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11);
    applyStimulus(1'b0, 2'b00, 2'b11);
    applyStimulus(1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11);

    // Per-bit independence.
    applyStimulus(1'b0, 2'b10, 2'b11);
    applyStimulus(1'b0, 2'b01, 2'b11);
    applyStimulus(1'b0, 2'b10, 2'b01);

    // Reset mid-stream with c at all ones.
    applyStimulus(1'b0, 2'b11, 2'b11);
    applyStimulus(1'b0, 2'b11, 2'b11);
    applyStimulus(1'b1, 2'b11, 2'b11);
    applyStimulus(1'b0, 2'b11, 2'b11);
    applyStimulus(1'b0, 2'b11, 2'b11);
    applyStimulus(1'b0, 2'b11, 2'b11);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    WIDTH'($urandom), WIDTH'($urandom));
    end

    // Let the last predictions drain, then confirm none were left behind.
    applyStimulus(1'b0, 2'b00, 2'b00);
    modelOn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending predictions expected 0",
               expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
